// File: rtl/hub75_scroll_scan_if.sv
// Row handshake between the game-graphics row source and the panel scanner.
interface hub75_scroll_scan_if #(
    parameter int unsigned COLS = 160
);
    logic            valid;
    logic            ready;
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;

    modport master (output valid, r, g, b, input ready);
    modport slave  (input valid, r, g, b, output ready);
endinterface

// File: rtl/hub75_scroll_scan.sv
// Scrolling two-half row buffer for a HUB75 panel with serial scan-out
// (pixel clock, latch, output enable, row address).
module hub75_scroll_scan #(
    parameter  int unsigned COLS = 160,
    parameter  int unsigned ROWS = 6,
    localparam int unsigned AW   = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    hub75_scroll_scan_if.slave  row_in,
    input  logic                chain,
    output logic                R0,
    output logic                G0,
    output logic                B0,
    output logic                R1,
    output logic                G1,
    output logic                B1,
    output logic                pclk,
    output logic                lat,
    output logic                oe_n,
    output logic [AW-1:0]       addr
);
    localparam int unsigned PW = $clog2(COLS);
    localparam int unsigned KW = PW + 1;

    typedef struct packed {
        logic [COLS-1:0] r;
        logic [COLS-1:0] g;
        logic [COLS-1:0] b;
    } row_t;

    typedef enum logic [1:0] {SHIFT, BLANK, LATCH, APPLY} state_t;

    state_t        state, state_d;
    logic [KW-1:0] k, k_d;
    logic [AW-1:0] scan_row, scan_row_d;

    row_t          u_buf [ROWS];
    row_t          l_buf [ROWS];
    row_t          stage;
    logic          pending;
    logic          accept;
    logic          scroll;

    row_t          cur_u;
    row_t          cur_l;
    logic [PW-1:0] col;

    logic [2:0]    pix_u_d;
    logic [2:0]    pix_l_d;
    logic          pclk_d;
    logic          lat_d;
    logic          oe_n_d;
    logic [AW-1:0] addr_d;

    assign row_in.ready = !pending && !rst;
    assign accept       = row_in.valid && row_in.ready;
    assign scroll       = (state == APPLY) && pending;

    // Pixel p of the row is shifted during k = 2p and 2p+1; bit COLS-1 is leftmost.
    assign cur_u = u_buf[scan_row];
    assign cur_l = l_buf[scan_row];
    assign col   = PW'(COLS - 1) - k[KW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SHIFT;
            k        <= '0;
            scan_row <= '0;
        end else begin
            state    <= state_d;
            k        <= k_d;
            scan_row <= scan_row_d;
        end
    end

    always_comb begin
        state_d    = state;
        k_d        = k;
        scan_row_d = scan_row;
        pix_u_d    = 3'b000;
        pix_l_d    = 3'b000;
        pclk_d     = 1'b0;
        lat_d      = 1'b0;
        oe_n_d     = 1'b1;
        addr_d     = addr;
        case (state)
            SHIFT: begin
                pclk_d  = k[0];
                oe_n_d  = 1'b0;
                pix_u_d = {cur_u.r[col], cur_u.g[col], cur_u.b[col]};
                pix_l_d = {cur_l.r[col], cur_l.g[col], cur_l.b[col]};
                if (k == KW'(2 * COLS - 1)) begin
                    state_d = BLANK;
                end else begin
                    k_d = k + KW'(1);
                end
            end
            BLANK: begin
                addr_d  = scan_row;
                state_d = LATCH;
            end
            LATCH: begin
                lat_d   = 1'b1;
                state_d = APPLY;
            end
            APPLY: begin
                k_d        = '0;
                scan_row_d = (scan_row == AW'(ROWS - 1)) ? '0 : scan_row + AW'(1);
                state_d    = SHIFT;
            end
            default: state_d = SHIFT;
        endcase
    end

    // Panel pins are registered copies of the per-state values above.
    always_ff @(posedge clk) begin
        if (rst) begin
            {R0, G0, B0} <= 3'b000;
            {R1, G1, B1} <= 3'b000;
            pclk         <= 1'b0;
            lat          <= 1'b0;
            oe_n         <= 1'b1;
            addr         <= '0;
        end else begin
            {R0, G0, B0} <= pix_u_d;
            {R1, G1, B1} <= pix_l_d;
            pclk         <= pclk_d;
            lat          <= lat_d;
            oe_n         <= oe_n_d;
            addr         <= addr_d;
        end
    end

    // Staging and scroll; scroll only happens between row scans, so no row tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            stage   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                u_buf[i] <= '0;
                l_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                stage   <= row_t'{r: row_in.r, g: row_in.g, b: row_in.b};
                pending <= 1'b1;
            end else if (scroll) begin
                pending <= 1'b0;
            end
            if (scroll) begin
                for (int i = 1; i < ROWS; i++) begin
                    u_buf[i] <= u_buf[i-1];
                    l_buf[i] <= l_buf[i-1];
                end
                u_buf[0] <= stage;
                l_buf[0] <= chain ? u_buf[ROWS-1] : stage;
            end
        end
    end

endmodule

// File: tb/tb_hub75_scroll_scan.sv
// Directed bench for hub75_scroll_scan at COLS=8, ROWS=4: scan cadence,
// scroll/chain behaviour, handshake pacing and mid-scan reset.
module tb_hub75_scroll_scan;
    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned AW   = 2;
    localparam int          RP   = 2 * COLS + 3;
    localparam int          FR   = ROWS * RP;
    localparam logic [3:0][7:0] Z4 = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chain = 1'b0;
    logic          R0, G0, B0, R1, G1, B1;
    logic          pclk, lat, oe_n;
    logic [AW-1:0] addr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] cap_r0 [ROWS];
    logic [7:0] cap_g0 [ROWS];
    logic [7:0] cap_b0 [ROWS];
    logic [7:0] cap_r1 [ROWS];
    logic [7:0] cap_g1 [ROWS];
    logic [7:0] cap_b1 [ROWS];
    int         cap_rise [ROWS];
    int         cap_lat [ROWS];
    int         cap_latph [ROWS];
    int         cap_oe [ROWS];
    int         cap_addr [ROWS];
    logic       cap_junk [ROWS];
    logic       cap_unst [ROWS];

    hub75_scroll_scan_if #(.COLS(COLS)) row_if ();

    hub75_scroll_scan #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk    (clk),
        .rst    (rst),
        .row_in (row_if),
        .chain  (chain),
        .R0     (R0),
        .G0     (G0),
        .B0     (B0),
        .R1     (R1),
        .G1     (G1),
        .B1     (B1),
        .pclk   (pclk),
        .lat    (lat),
        .oe_n   (oe_n),
        .addr   (addr)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 is the first cycle after the reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        row_if.valid = 1'b0;
        @(negedge clk);
        check("ready_in_rst", 32'(row_if.ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " pix"},   32'({R0, G0, B0, R1, G1, B1}), 32'd0);
        check({tag, " pclk"},  32'(pclk), 32'd0);
        check({tag, " lat"},   32'(lat), 32'd0);
        check({tag, " oe_n"},  32'(oe_n), 32'd1);
        check({tag, " addr"},  32'(addr), 32'd0);
        check({tag, " ready"}, 32'(row_if.ready), 32'd1);
    endtask

    task automatic push_row(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!row_if.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!row_if.ready) check("push_timeout", 32'(row_if.ready), 32'd1);
        row_if.valid = 1'b1;
        row_if.r = r;
        row_if.g = g;
        row_if.b = b;
        @(posedge clk);
        #1 row_if.valid = 1'b0;
    endtask

    // Samples the pins over frame f (pin cycles FR*(f-1)+1 .. FR*f).
    task automatic capture_frame(input int f);
        int first;
        int guard;
        logic pp;
        logic [5:0] pix;
        logic [5:0] prev_pix;
        first = FR * (f - 1) + 1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc < first && guard < 100000);
        check($sformatf("align f%0d", f), cyc, first);
        for (int j = 0; j < ROWS; j++) begin
            cap_r0[j] = '0; cap_g0[j] = '0; cap_b0[j] = '0;
            cap_r1[j] = '0; cap_g1[j] = '0; cap_b1[j] = '0;
            cap_rise[j] = 0; cap_lat[j] = 0; cap_latph[j] = -1;
            cap_oe[j] = 0; cap_addr[j] = -1;
            cap_junk[j] = 1'b0; cap_unst[j] = 1'b0;
        end
        pp = 1'b0;
        prev_pix = '0;
        for (int i = 0; i < FR; i++) begin
            int j;
            int ph;
            int p;
            if (i > 0) @(negedge clk);
            j = i / RP;
            ph = i % RP;
            pix = {R0, G0, B0, R1, G1, B1};
            if (pclk && !pp) cap_rise[j]++;
            pp = pclk;
            if (lat) begin
                cap_lat[j]++;
                cap_latph[j] = ph;
                cap_addr[j] = int'(addr);
            end
            if (oe_n) cap_oe[j]++;
            if (ph >= 2 * COLS) begin
                if (pix != 6'd0) cap_junk[j] = 1'b1;
            end else if (ph % 2 == 1) begin
                p = ph / 2;
                cap_r0[j][7-p] = R0; cap_g0[j][7-p] = G0; cap_b0[j][7-p] = B0;
                cap_r1[j][7-p] = R1; cap_g1[j][7-p] = G1; cap_b1[j][7-p] = B1;
                if (pix != prev_pix) cap_unst[j] = 1'b1;
            end
            prev_pix = pix;
        end
    endtask

    task automatic check_frame(input string tag,
                               input logic [3:0][7:0] ur, input logic [3:0][7:0] ug,
                               input logic [3:0][7:0] ub, input logic [3:0][7:0] lr,
                               input logic [3:0][7:0] lg, input logic [3:0][7:0] lb);
        for (int j = 0; j < ROWS; j++) begin
            check($sformatf("%s row%0d upper", tag, j),
                  32'({cap_r0[j], cap_g0[j], cap_b0[j]}), 32'({ur[j], ug[j], ub[j]}));
            check($sformatf("%s row%0d lower", tag, j),
                  32'({cap_r1[j], cap_g1[j], cap_b1[j]}), 32'({lr[j], lg[j], lb[j]}));
            check($sformatf("%s row%0d pclk_rises", tag, j), cap_rise[j], COLS);
            check($sformatf("%s row%0d lat_cycles", tag, j), cap_lat[j], 1);
            check($sformatf("%s row%0d lat_phase", tag, j), cap_latph[j], 2 * COLS + 1);
            check($sformatf("%s row%0d oe_high", tag, j), cap_oe[j], 3);
            check($sformatf("%s row%0d addr", tag, j), cap_addr[j], j);
            check($sformatf("%s row%0d blank_pix", tag, j), 32'(cap_junk[j]), 32'd0);
            check($sformatf("%s row%0d pix_stable", tag, j), 32'(cap_unst[j]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][7:0] eur, eug, eub, elr, elg, elb;
        int n_low;
        int n_acc;
        int acc_cyc [2];

        row_if.valid = 1'b0;
        row_if.r = '0;
        row_if.g = '0;
        row_if.b = '0;

        // Reset state, zero first frame, single push with chain=0.
        chain = 1'b0;
        do_reset();
        row_if.valid = 1'b1;
        row_if.r = 8'b1000_0001;
        row_if.g = '0;
        row_if.b = '0;
        @(negedge clk);
        check_reset("rst1");
        @(posedge clk);
        #1 row_if.valid = 1'b0;
        fork
            begin
                n_low = 0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (row_if.ready) break;
                    n_low++;
                end
                check("t3 ready_low_cycles", n_low, 18);
                check("t3 ready_rise_cyc", cyc, 19);
            end
            begin
                capture_frame(1);
                check_frame("t3f1", Z4, Z4, Z4, Z4, Z4, Z4);
                capture_frame(2);
                eur = Z4;
                eur[0] = 8'b1000_0001;
                check_frame("t3f2", eur, Z4, Z4, eur, Z4, Z4);
            end
        join

        // Chained halves: bottom of upper half feeds top of lower half.
        chain = 1'b1;
        do_reset();
        fork
            begin
                push_row(8'hC0, 8'h00, 8'h00);
                push_row(8'h30, 8'h00, 8'h00);
                push_row(8'h0C, 8'h00, 8'h00);
                push_row(8'h03, 8'h00, 8'h00);
            end
            begin
                capture_frame(1);
                check_frame("t4f1", Z4, Z4, Z4, Z4, Z4, Z4);
                capture_frame(2);
                eur[0] = 8'h03; eur[1] = 8'h0C; eur[2] = 8'h30; eur[3] = 8'hC0;
                check_frame("t4f2", eur, Z4, Z4, Z4, Z4, Z4);
            end
        join
        push_row(8'h5A, 8'h00, 8'h00);
        capture_frame(4);
        eur[0] = 8'h5A; eur[1] = 8'h03; eur[2] = 8'h0C; eur[3] = 8'h30;
        elr = Z4;
        elr[0] = 8'hC0;
        check_frame("t4f4", eur, Z4, Z4, elr, Z4, Z4);

        // valid held high across two rows: one accept per APPLY, order kept.
        chain = 1'b0;
        do_reset();
        row_if.valid = 1'b1;
        row_if.r = 8'h18; row_if.g = 8'h81; row_if.b = 8'h00;
        n_acc = 0;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        for (int t = 0; t < 200 && n_acc < 2; t++) begin
            @(negedge clk);
            if (row_if.ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 1) begin
                    row_if.r = 8'h24; row_if.g = 8'h00; row_if.b = 8'h42;
                end else begin
                    row_if.valid = 1'b0;
                end
            end
        end
        row_if.valid = 1'b0;
        check("t5 accept_count", n_acc, 2);
        check("t5 accept0_cyc", acc_cyc[0], 0);
        check("t5 accept1_cyc", acc_cyc[1], 19);
        eur = Z4; eug = Z4; eub = Z4;
        eur[0] = 8'h24; eub[0] = 8'h42;
        eur[1] = 8'h18; eug[1] = 8'h81;
        elr = eur; elg = eug; elb = eub;
        capture_frame(2);
        check_frame("t5f2", eur, eug, eub, elr, elg, elb);
        capture_frame(3);
        check_frame("t5f3", eur, eug, eub, elr, elg, elb);

        // Reset during SHIFT k=5 with a staged row: staged row is dropped.
        do_reset();
        push_row(8'hFF, 8'hFF, 8'hFF);
        while (cyc < 5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("t6");
        capture_frame(1);
        check_frame("t6f1", Z4, Z4, Z4, Z4, Z4, Z4);
        capture_frame(2);
        check_frame("t6f2", Z4, Z4, Z4, Z4, Z4, Z4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
